bpm_beat_gen: RTL
=================

Name: bpm_beat_gen

Overview:
Synthetic heartbeat source and the inverse of the BPM calculator. It takes a target heart rate in BPM and computes the R-R interval in clock cycles as 60*CLK_FREQ/bpm, using an iterative restoring divider. It then emits a periodic beat pulse train at that interval. It drives the R-R measurement and BPM calculation path during self-test and closed-loop simulation.

Parameters:
CLK_FREQ, 200, clock frequency in Hz; the dividend is the constant 60*CLK_FREQ, which must fit in 32 bits.
PULSE_WIDTH, 4, beat high time in cycles; must be less than the interval at BPM_MAX.
BPM_MIN, 20, lowest accepted BPM, inclusive.
BPM_MAX, 250, highest accepted BPM, inclusive.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
enable  input  1  beat generator run; low holds the phase counter at 0 and forces beat low
bpm_load  input  1  single-cycle strobe; requests a new target rate
bpm_in  input  32  target BPM, sampled when bpm_load is accepted
busy  output  1  divider running; new loads are ignored
rr_valid  output  1  single-cycle pulse when rr_cycles_out updates
rr_cycles_out  output  32  latest computed interval in cycles
err_range  output  1  last load attempt had bpm_in outside [BPM_MIN, BPM_MAX]
beat  output  1  synthetic heartbeat pulse

Behaviour:
- Reset: all outputs and all internal state go to 0; divider FSM goes to IDLE. This includes active_rr, pending_rr and the phase counter. Reset mid-division aborts it and no rr_valid is produced.
- FSM states: IDLE, DIV, DONE.
- IDLE, bpm_load=1 and bpm_in in range, at edge L:
  - latch bpm_in as divisor; dividend = 60*CLK_FREQ; quotient and remainder = 0; iter = 0.
  - busy=1, err_range=0; go to DIV.
- IDLE, bpm_load=1 and bpm_in out of range (0 included): err_range=1; stay in IDLE; busy stays 0; stored intervals unchanged.
- DIV: one restoring-divide step per cycle, MSB first, for 32 iterations at edges L+1..L+32; after iteration 31, go to DONE.
  - Each step: rem = {rem[30:0], dividend bit}; if rem >= divisor, subtract and set the quotient bit.
- DONE, edge L+33:
  - rr_cycles_out = quotient (floor; remainder discarded); pending_rr = quotient.
  - rr_valid=1 for this one cycle; busy=0; go to IDLE.
- Load latency: busy is high for exactly 33 cycles after the accepting edge L.
- bpm_load while busy: ignored, with no effect on err_range or the FSM.
- Interval hand-over:
  - If enable=0 or active_rr=0 at DONE: active_rr = pending_rr immediately and the phase counter is cleared.
  - Otherwise: active_rr takes pending_rr at the next period wrap, so the current period always completes glitch-free.
- Beat generator, per edge with enable=1 and active_rr != 0:
  - beat <= (cnt < PULSE_WIDTH).
  - If cnt == active_rr-1: cnt <= 0 and the pending interval is applied. Otherwise cnt <= cnt+1.
  - First beat rises after the first edge that samples enable high; rising edges are exactly active_rr cycles apart; high time is exactly PULSE_WIDTH cycles.
- enable=0: cnt <= 0 and beat <= 0 on the next edge; re-enable restarts the phase from 0.
- active_rr = 0 (no valid load since reset): beat stays 0 regardless of enable.
- Load completes on the same edge as a period wrap: the wrap uses the old pending_rr. The new value is applied at the following wrap.
- Arithmetic: all 32-bit unsigned; the range check guarantees divisor ≥ 1, so there is no divide-by-zero.

Test Plan:
1. Reset, bpm_load with bpm_in=60, then enable=1 → busy high 33 cycles; rr_valid pulses once; rr_cycles_out=200; beat rising edges 200 cycles apart, each high 4 cycles.
2. Load bpm_in=70 → rr_cycles_out=171 (12000/70 floored); load bpm_in=250 → 48; load bpm_in=20 → 600.
3. Load bpm_in=19, then 251, then 0 → err_range=1 each time; busy never asserts; rr_cycles_out and beat period unchanged. A following load of 75 → err_range=0, rr_cycles_out=160.
4. Running at 200-cycle period, load 75 mid-period → current period finishes at 200 cycles; every later period is 160 cycles; no short or runt pulse.
5. Second bpm_load pulsed while busy → ignored; only the first value appears on rr_cycles_out, with a single rr_valid.
6. Assert rst at iteration 10 of DIV, then toggle enable mid-beat → all outputs 0; no rr_valid; beat stays 0 until a new load completes. After the load, disable forces beat low next cycle, and re-enable restarts with beat high on the first enabled edge.

Source files
------------

// File: rtl/bpm_beat_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bpm_beat_gen                                               |
// | Brief   : Synthetic heartbeat source. Converts a target BPM into an  |
// |           R-R interval (60*CLK_FREQ/bpm) with a 32-step restoring    |
// |           divider and emits a periodic beat pulse at that interval.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bpm_beat_gen #(
  parameter int unsigned CLK_FREQ    = 200,
  parameter int unsigned PULSE_WIDTH = 4,
  parameter int unsigned BPM_MIN     = 20,
  parameter int unsigned BPM_MAX     = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        bpm_load,
  input  logic [31:0] bpm_in,
  output logic        busy,
  output logic        rr_valid,
  output logic [31:0] rr_cycles_out,
  output logic        err_range,
  output logic        beat
);

  // Cycles per minute: the fixed dividend of every interval computation.
  localparam logic [31:0] c_dividend = 32'(60 * CLK_FREQ);
  localparam logic [31:0] c_bpm_min  = 32'(BPM_MIN);
  localparam logic [31:0] c_bpm_max  = 32'(BPM_MAX);
  localparam logic [31:0] c_pw       = 32'(PULSE_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  iter_q, iter_d;
  logic [31:0] rr_out_q, rr_out_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] active_q, active_d;
  logic [31:0] cnt_q, cnt_d;
  logic        beat_q, beat_d;

  logic        w_in_range;
  logic [32:0] w_rem_shift;
  logic        w_fits;
  logic        w_run;
  logic        w_wrap;

  assign w_in_range  = (bpm_in >= c_bpm_min) && (bpm_in <= c_bpm_max);
  // Restoring step: bring in the next dividend bit, MSB first.
  assign w_rem_shift = {rem_q, c_dividend[5'd31 - iter_q]};
  assign w_fits      = (w_rem_shift >= {1'b0, divisor_q});
  assign w_run       = enable && (active_q != 32'd0);
  assign w_wrap      = (cnt_q == (active_q - 32'd1));

  // Next-state logic for the divider FSM and the beat phase counter.
  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    iter_d    = iter_q;
    rr_out_d  = rr_out_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    pending_d = pending_q;
    active_d  = active_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;

    case (state_q)
      ST_IDLE: begin
        if (bpm_load) begin
          if (w_in_range) begin
            divisor_d = bpm_in;
            rem_d     = 32'd0;
            quo_d     = 32'd0;
            iter_d    = 5'd0;
            err_d     = 1'b0;
            state_d   = ST_DIV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DIV: begin
        rem_d  = w_fits ? 32'(w_rem_shift - {1'b0, divisor_q}) : w_rem_shift[31:0];
        quo_d  = {quo_q[30:0], w_fits};
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd31) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        rr_out_d  = quo_q;
        pending_d = quo_q;
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Beat phase: a running period always completes on its old interval;
    // a freshly computed interval is picked up at the wrap.
    if (!w_run) begin
      cnt_d  = 32'd0;
      beat_d = 1'b0;
    end else begin
      beat_d = (cnt_q < c_pw);
      if (w_wrap) begin
        cnt_d    = 32'd0;
        active_d = pending_q;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    // Nothing is running, so a new interval can take effect immediately.
    if ((state_q == ST_DONE) && !w_run) begin
      active_d = quo_q;
      cnt_d    = 32'd0;
    end
  end

  // State register; asynchronous reset clears everything, aborting a division.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      divisor_q <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      iter_q    <= 5'd0;
      rr_out_q  <= 32'd0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      pending_q <= 32'd0;
      active_q  <= 32'd0;
      cnt_q     <= 32'd0;
      beat_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      iter_q    <= iter_d;
      rr_out_q  <= rr_out_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign rr_valid      = valid_q;
  assign rr_cycles_out = rr_out_q;
  assign err_range     = err_q;
  assign beat          = beat_q;

endmodule
`default_nettype wire
